seg_display_scanner: RTL and testbench
======================================

# seg_display_scanner

Time-multiplexed scan controller for a 7-segment display bank. It holds a 32-bit word, or in general 4×NUM_DIGITS bits. It drives one digit at a time: the current nibble goes to the downstream BCD-to-seven-segment decoder, and the matching active-low digit enable goes to the display. It sits between the word source (the UART word receiver or any other producer pulsing `load`) and the segment decoder. Word updates are deferred to frame boundaries so the display never shows a mix of two words.

## Interface
- `NUM_DIGITS`, default 8: digits scanned, legal range 1..8; word width is 4×NUM_DIGITS.
- `REFRESH_DIV`, default 100000: clock cycles each digit is selected; must be ≥ 2.
- `DEAD_CYCLES`, default 16: cycles at the start of each digit slot with all enables off (anti-ghosting); must be < REFRESH_DIV.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `word_in` in 4×NUM_DIGITS: word to display; nibble 0 is `word_in[3:0]` (rightmost digit).
- `load` in 1: single-cycle strobe; captures `word_in`.
- `blank_lz` in 1: 1 = suppress leading zeros.
- `nibble` out 4: value for the segment decoder.
- `digit_en_n` out NUM_DIGITS: active-low digit enables; at most one bit low.
- `frame_tick` out 1: one-cycle pulse at each frame boundary.

## Operation
- **Prescaler `cnt`**
  - Counts 0..REFRESH_DIV-1.
  - At terminal count: `cnt` goes to 0 and `idx` goes to (idx+1) mod NUM_DIGITS.
- **Frame boundary**
  - Defined as the cycle where `cnt`=REFRESH_DIV-1 and `idx`=NUM_DIGITS-1.
  - On that cycle: if `pending_vld`=1, then `disp` takes `pending` and `pending_vld` is cleared.
  - `frame_tick` asserts for that cycle only, whether or not a word is pending.
- **Load**
  - When `load`=1, `pending` takes `word_in` and `pending_vld` is set.
  - Several loads within one frame: the last one wins.
  - Load coinciding with a frame boundary:
    - the boundary consumes the previous `pending` (the value before that cycle);
    - the new word stays pending and applies at the next boundary.
- **Blanking**
  - Digit i (i ≥ 1) is blanked when `blank_lz`=1 and nibbles i..NUM_DIGITS-1 of `disp` are all zero.
  - Digit 0 is never blanked.
- **Enables**
  - `digit_en_n[idx]`=0 only when `cnt` ≥ DEAD_CYCLES and digit `idx` is not blanked.
  - Otherwise `digit_en_n` is all ones.
- **Nibble**
  - `nibble` = nibble `idx` of `disp`, driven even during dead time or blanking.
- **Reset values:** `cnt`=0, `idx`=0, `disp`=0, `pending`=0, `pending_vld`=0, `nibble`=0, `digit_en_n`=all ones, `frame_tick`=0.
- **Reset mid-scan:** immediate return to reset values; any pending word is discarded.

## Timing
- `nibble` and `digit_en_n` are registered and reflect `cnt`/`idx`/`disp` from the previous cycle (one-cycle lag); `frame_tick` is registered the same way.
- Digit slot: REFRESH_DIV cycles, of which DEAD_CYCLES have enables off.
- Frame: NUM_DIGITS×REFRESH_DIV cycles.
- Load-to-display latency:
  - `disp` updates on the first frame boundary strictly after the `load` cycle;
  - the new value appears on outputs one cycle after that boundary;
  - worst case is about 2 frames (load on a boundary cycle).
- `blank_lz` is sampled every cycle; a change takes effect on outputs one cycle later, with no frame alignment.
- After reset release: digit 0 is enabled at cycle DEAD_CYCLES+1 showing 0; the first `frame_tick` is at cycle NUM_DIGITS×REFRESH_DIV-1.

## Structure
- Package `display_pkg` holds:
  - `MAX_DIGITS`=8;
  - typedef `nibble_t` (logic [3:0]);
  - typedef `digit_mask_t` (logic [MAX_DIGITS-1:0]).
- Sub-module `refresh_prescaler` owns `cnt` and the `idx` wrap. It outputs `idx`, `slot_end`, `frame_end` and `in_dead`.
- Top level contains the pending/display registers, the leading-zero mask, and the output registers; it instantiates the existing segment decoder externally, not inside this block.

## Test plan
Bench settings: NUM_DIGITS=8, REFRESH_DIV=4, DEAD_CYCLES=1.
- **Reset state:** hold `rst_n`=0 → `digit_en_n`=8'hFF, `nibble`=0, `frame_tick`=0. Release → first `frame_tick` at cycle 31.
- **Scan order:** `load` 32'h89ABCDEF, wait past boundary → slots show `nibble` F,E,D,C,B,A,9,8 with `digit_en_n` = 8'hFE, FD, FB, …, 7F. Each enable is low 3 of 4 cycles.
- **Leading-zero blanking:** `blank_lz`=1, word 32'h00000A05 → digits 0,1,2 enabled showing 5,0,A; digits 3..7 keep `digit_en_n` all ones. Word 32'h0 → only digit 0 shows 0.
- **Tear-free update and last-wins:**
  - load 32'h11111111 mid-frame → no output change until after `frame_tick`;
  - two loads (22222222 then 33333333) in one frame → only 3s are displayed.
- **Load on boundary:** `pending`=44444444, and a load of 55555555 coincides with the boundary → the 4s display this frame; the 5s appear only after the next `frame_tick`.
- **Reset mid-operation:** assert `rst_n`=0 during digit 5 with a word pending → outputs return to reset values asynchronously; after release, `disp`=0 and the pending word is never shown.

Source files
------------

// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg - shared types and limits for the 7-segment scan controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package display_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int IDX_W      = $clog2(MAX_DIGITS);

    typedef logic [3:0]            nibble_t;
    typedef logic [MAX_DIGITS-1:0] digit_mask_t;
    typedef logic [IDX_W-1:0]      digit_idx_t;

endpackage

`default_nettype wire

// File: rtl/refresh_prescaler.sv
// ============================================================================
// refresh_prescaler - per-digit slot timer and digit index sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module refresh_prescaler
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    output digit_idx_t idx_o,
    output logic       slot_end_o,
    output logic       frame_end_o,
    output logic       in_dead_o
);

    localparam int                CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  DEAD_END = CNT_W'(DEAD_CYCLES);
    localparam digit_idx_t        IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;

    assign slot_end_o  = (cnt_q == CNT_LAST);
    assign frame_end_o = slot_end_o && (idx_q == IDX_LAST);
    assign in_dead_o   = (cnt_q < DEAD_END);
    assign idx_o       = idx_q;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_end_o) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_display_scanner.sv
// ============================================================================
// seg_display_scanner - tear-free multiplexed scan of a 7-segment display bank
// with leading-zero blanking and frame-aligned word updates.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] word_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output nibble_t                 nibble,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_tick
);

    localparam int WORD_W = 4 * NUM_DIGITS;

    logic [WORD_W-1:0]     disp_q;
    logic [WORD_W-1:0]     pending_q;
    logic                  pending_vld_q;
    nibble_t               nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0] en_n_q, en_n_d;
    logic                  frame_tick_q;

    digit_idx_t            idx;
    logic                  slot_end;
    logic                  frame_end;
    logic                  in_dead;
    digit_mask_t           blanked;
    logic                  upper_zero;

    refresh_prescaler #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_prescaler (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_o       (idx),
        .slot_end_o  (slot_end),
        .frame_end_o (frame_end),
        .in_dead_o   (in_dead)
    );

    // Digit i blanks only when it and every more-significant nibble are zero.
    always_comb begin
        blanked    = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (disp_q[4*i +: 4] == 4'h0);
            blanked[i] = blank_lz & upper_zero;
        end
    end

    always_comb begin
        nibble_d = '0;
        en_n_d   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nibble_d = disp_q[4*i +: 4];
                if (!in_dead && !blanked[i]) begin
                    en_n_d[i] = 1'b0;
                end
            end
        end
    end

    // A load on the boundary cycle leaves the old pending word to be consumed
    // and keeps the new one pending for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q        <= '0;
            pending_q     <= '0;
            pending_vld_q <= 1'b0;
            nibble_q      <= '0;
            en_n_q        <= '1;
            frame_tick_q  <= 1'b0;
        end else begin
            if (frame_end && pending_vld_q) begin
                disp_q <= pending_q;
            end
            if (load) begin
                pending_q     <= word_in;
                pending_vld_q <= 1'b1;
            end else if (frame_end) begin
                pending_vld_q <= 1'b0;
            end
            nibble_q     <= nibble_d;
            en_n_q       <= en_n_d;
            frame_tick_q <= frame_end;
        end
    end

    assign nibble     = nibble_q;
    assign digit_en_n = en_n_q;
    assign frame_tick = frame_tick_q;

    a_frame_in_slot_end : assert property (@(posedge clk) disable iff (!rst_n)
        frame_end |-> slot_end);

endmodule

`default_nettype wire

// File: tb/tb_seg_display_scanner.sv
// ============================================================================
// tb_seg_display_scanner - directed vectors for the scan controller
// (8 digits, 4-cycle slots, 1 dead cycle).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg_display_scanner;

    localparam int N = 8;
    localparam int R = 4;
    localparam int D = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] word_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  nibble;
    logic [7:0]  digit_en_n;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] word;
        logic        blank;
        logic [7:0]  lit;
    } vec_t;

    vec_t vecs [6];

    seg_display_scanner #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .DEAD_CYCLES (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_in    (word_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .nibble     (nibble),
        .digit_en_n (digit_en_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at #1 after the edge on which frame_tick became visible; checks
    // one full frame of w with digits in lit enabled, optionally issuing loads.
    task automatic check_frame(input logic [31:0] w, input logic [7:0] lit,
                               input int la1, input logic [31:0] lw1,
                               input int la2, input logic [31:0] lw2,
                               input string tag);
        int d, c;
        logic [3:0] exp_nib;
        logic [7:0] exp_en;
        for (int k = 0; k < N * R; k++) begin
            @(posedge clk);
            #1;
            load = 1'b0;
            d = k / R;
            c = k % R;
            exp_nib = w[d*4 +: 4];
            exp_en  = (c >= D && lit[d]) ? ~(8'h01 << d) : 8'hFF;
            chk($sformatf("%s nibble k=%0d", tag, k), {28'h0, nibble}, {28'h0, exp_nib});
            chk($sformatf("%s en_n k=%0d", tag, k), {24'h0, digit_en_n}, {24'h0, exp_en});
            chk($sformatf("%s tick k=%0d", tag, k), {31'h0, frame_tick}, {31'h0, k == N * R - 1});
            if (k == la1) begin word_in = lw1; load = 1'b1; end
            if (k == la2) begin word_in = lw2; load = 1'b1; end
        end
        load = 1'b0;
    endtask

    // Releases reset; slot timing starts at cnt=0, so the first enable shows up
    // after edge D+1 and the first boundary (cycle 31) is visible after edge 32.
    task automatic release_and_check(input string tag);
        int first_tick;
        first_tick = -1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 40 && first_tick < 0; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) chk({tag, " en_n dead"}, {24'h0, digit_en_n}, 32'hFF);
            if (n == 2) begin
                chk({tag, " en_n first"}, {24'h0, digit_en_n}, 32'hFE);
                chk({tag, " nibble first"}, {28'h0, nibble}, 32'h0);
            end
            if (frame_tick) first_tick = n;
        end
        chk({tag, " first tick edge"}, first_tick, 32);
    endtask

    initial begin
        vecs[0] = '{word: 32'h89ABCDEF, blank: 1'b0, lit: 8'hFF};
        vecs[1] = '{word: 32'h00000A05, blank: 1'b1, lit: 8'h07};
        vecs[2] = '{word: 32'h00000000, blank: 1'b1, lit: 8'h01};
        vecs[3] = '{word: 32'h00000A05, blank: 1'b0, lit: 8'hFF};
        vecs[4] = '{word: 32'h10000000, blank: 1'b1, lit: 8'hFF};
        vecs[5] = '{word: 32'h0000F000, blank: 1'b1, lit: 8'h0F};

        repeat (3) @(posedge clk);
        #1;
        chk("reset en_n", {24'h0, digit_en_n}, 32'hFF);
        chk("reset nibble", {28'h0, nibble}, 32'h0);
        chk("reset tick", {31'h0, frame_tick}, 32'h0);

        release_and_check("boot");

        begin
            logic [31:0] prev_w;
            logic [7:0]  prev_lit;
            prev_w   = 32'h0;
            prev_lit = 8'hFF;
            for (int i = 0; i < 6; i++) begin
                check_frame(prev_w, prev_lit, 3, vecs[i].word, -1, 32'h0,
                            $sformatf("v%0d hold", i));
                blank_lz = vecs[i].blank;
                check_frame(vecs[i].word, vecs[i].lit, -1, 32'h0, -1, 32'h0,
                            $sformatf("v%0d show", i));
                prev_w   = vecs[i].word;
                prev_lit = vecs[i].lit;
            end
        end

        blank_lz = 1'b0;
        check_frame(32'h0000F000, 8'hFF, 10, 32'h11111111, -1, 32'h0, "tear hold");
        check_frame(32'h11111111, 8'hFF, 5, 32'h22222222, 20, 32'h33333333, "tear show");
        check_frame(32'h33333333, 8'hFF, 5, 32'h44444444, 30, 32'h55555555, "last wins");
        check_frame(32'h44444444, 8'hFF, -1, 32'h0, -1, 32'h0, "boundary old");
        check_frame(32'h55555555, 8'hFF, -1, 32'h0, -1, 32'h0, "boundary new");

        // Mid-scan reset with 66666666 pending, taken during digit 5.
        @(posedge clk);
        #1;
        word_in = 32'h66666666;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("pre-reset nibble", {28'h0, nibble}, 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset en_n", {24'h0, digit_en_n}, 32'hFF);
        chk("async reset nibble", {28'h0, nibble}, 32'h0);
        chk("async reset tick", {31'h0, frame_tick}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("held reset en_n", {24'h0, digit_en_n}, 32'hFF);

        release_and_check("rerun");
        check_frame(32'h0, 8'hFF, -1, 32'h0, -1, 32'h0, "discard");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
